// File: rtl/crc_pkg.sv
// Shared constants, FSM state type and LFSR step function for the serial CRC-8
// generator/checker pair.
package crc_pkg;

   localparam int CRC_W = 8;
   localparam logic [CRC_W-1:0] CRC_SEED = 8'hD8;
   localparam logic [CRC_W-1:0] CRC_TAPS = 8'b0100_0100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_CRC    = 2'd2,
      ST_REPORT = 2'd3
   } crc_state_t;

   // One data bit through the LFSR; the top bit only ever receives raw feedback.
   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] l,
                                                 input logic [CRC_W-1:0] taps,
                                                 input logic din);
      logic fb;
      fb = din ^ l[0];
      crc_step = {fb, l[CRC_W-1:1]} ^ (taps & {1'b0, {(CRC_W-1){fb}}});
   endfunction

endpackage

// File: rtl/crc_lfsr.sv
// 8-bit CRC LFSR shared by generator and checker: seed load, data feedback
// shift, and plain right shift for serialising the remainder out of bit 0.
module crc_lfsr
   import crc_pkg::*;
#(
   parameter logic [CRC_W-1:0] SEED = CRC_SEED,
   parameter logic [CRC_W-1:0] TAPS = CRC_TAPS
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic shift_data,
   input  logic shift_out,
   input  logic din,
   output logic lsb
);

   logic [CRC_W-1:0] lfsr;
   logic [CRC_W-1:0] base;

   // A load combined with a shift operates on the seed in the same cycle.
   always_comb begin
      base = load ? SEED : lfsr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= SEED;
      end else if (shift_data) begin
         lfsr <= crc_step(base, TAPS, din);
      end else if (shift_out) begin
         lfsr <= {1'b0, base[CRC_W-1:1]};
      end else if (load) begin
         lfsr <= SEED;
      end
   end

   assign lsb = lfsr[0];

endmodule

// File: rtl/crc_checker.sv
// Serial CRC-8 receiver/checker with one-cycle verdict strobe.
// Define CRC_CHK_ERRCNT_EN to build the saturating failed-frame counter on ERR_CNT.
module crc_checker
   import crc_pkg::*;
#(
   parameter logic [CRC_W-1:0] SEED = CRC_SEED,
   parameter logic [CRC_W-1:0] TAPS = CRC_TAPS
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             DATA,
   input  logic             ACTIVE,
   input  logic             CRC_IN,
   input  logic             CRC_VLD,
   output logic             DONE,
   output logic             CRC_OK,
   output logic             LEN_ERR,
   output logic [CRC_W-1:0] ERR_CNT
);

   crc_state_t state;
   crc_state_t state_nxt;

   logic       lfsr_load;
   logic       lfsr_shift_data;
   logic       lfsr_shift_out;
   logic       lfsr_lsb;
   logic       take_crc;
   logic       flag_len;
   logic [2:0] bit_cnt;
   logic       mismatch;
   logic       len_err;

   crc_lfsr #(
      .SEED (SEED),
      .TAPS (TAPS)
   ) u_lfsr (
      .clk        (CLK),
      .rst        (RST),
      .load       (lfsr_load),
      .shift_data (lfsr_shift_data),
      .shift_out  (lfsr_shift_out),
      .din        (DATA),
      .lsb        (lfsr_lsb)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      lfsr_load       = 1'b0;
      lfsr_shift_data = 1'b0;
      lfsr_shift_out  = 1'b0;
      take_crc        = 1'b0;
      flag_len        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ACTIVE) begin
               lfsr_load       = 1'b1;
               lfsr_shift_data = 1'b1;
               state_nxt       = ST_DATA;
            end
         end
         ST_DATA: begin
            // ACTIVE has priority; a concurrent CRC_VLD bit is treated as data.
            if (ACTIVE) begin
               lfsr_shift_data = 1'b1;
            end else if (CRC_VLD) begin
               take_crc       = 1'b1;
               lfsr_shift_out = 1'b1;
               state_nxt      = (bit_cnt == 3'd7) ? ST_REPORT : ST_CRC;
            end
         end
         ST_CRC: begin
            if (ACTIVE) begin
               flag_len  = 1'b1;
               state_nxt = ST_REPORT;
            end else if (CRC_VLD) begin
               take_crc       = 1'b1;
               lfsr_shift_out = 1'b1;
               if (bit_cnt == 3'd7) begin
                  state_nxt = ST_REPORT;
               end
            end else begin
               flag_len  = 1'b1;
               state_nxt = ST_REPORT;
            end
         end
         ST_REPORT: begin
            if (ACTIVE) begin
               lfsr_load       = 1'b1;
               lfsr_shift_data = 1'b1;
               state_nxt       = ST_DATA;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      DONE    = 1'b0;
      CRC_OK  = 1'b0;
      LEN_ERR = 1'b0;
      if (state == ST_REPORT) begin
         DONE    = 1'b1;
         CRC_OK  = !mismatch && !len_err;
         LEN_ERR = len_err;
      end
   end

   // Counter wraps 7->0 naturally on the 8th bit, which is also the REPORT entry.
   always_ff @(posedge CLK) begin
      if (RST) begin
         bit_cnt  <= 3'd0;
         mismatch <= 1'b0;
         len_err  <= 1'b0;
      end else if (state == ST_REPORT) begin
         bit_cnt  <= 3'd0;
         mismatch <= 1'b0;
         len_err  <= 1'b0;
      end else begin
         if (take_crc) begin
            mismatch <= mismatch | (CRC_IN ^ lfsr_lsb);
            bit_cnt  <= bit_cnt + 3'd1;
         end
         if (flag_len) begin
            len_err <= 1'b1;
         end
      end
   end

`ifdef CRC_CHK_ERRCNT_EN
   function automatic logic [CRC_W-1:0] sat_inc(input logic [CRC_W-1:0] v);
      sat_inc = (v == {CRC_W{1'b1}}) ? v : v + CRC_W'(1);
   endfunction

   logic [CRC_W-1:0] err_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         err_cnt_q <= '0;
      end else if (DONE && !CRC_OK) begin
         err_cnt_q <= sat_inc(err_cnt_q);
      end
   end

   assign ERR_CNT = err_cnt_q;
`else
   assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_crc_checker.sv
// Directed bench for crc_checker: good/bad CRC, short and interrupted CRC phase,
// back-to-back frames, mid-frame reset and error-counter saturation.
module tb_crc_checker;
   import crc_pkg::*;

   logic       CLK;
   logic       RST;
   logic       DATA;
   logic       ACTIVE;
   logic       CRC_IN;
   logic       CRC_VLD;
   logic       DONE;
   logic       CRC_OK;
   logic       LEN_ERR;
   logic [7:0] ERR_CNT;

   int total = 0;
   int bad   = 0;

`ifdef CRC_CHK_ERRCNT_EN
   localparam logic EC = 1'b1;
`else
   localparam logic EC = 1'b0;
`endif

   crc_checker dut (
      .CLK     (CLK),
      .RST     (RST),
      .DATA    (DATA),
      .ACTIVE  (ACTIVE),
      .CRC_IN  (CRC_IN),
      .CRC_VLD (CRC_VLD),
      .DONE    (DONE),
      .CRC_OK  (CRC_OK),
      .LEN_ERR (LEN_ERR),
      .ERR_CNT (ERR_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [7:0] ec_exp(input int n);
      ec_exp = EC ? 8'(n) : 8'h00;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_data(input logic [7:0] d, input logic vld_too);
      for (int i = 0; i < 8; i++) begin
         ACTIVE  = 1'b1;
         DATA    = d[i];
         CRC_VLD = vld_too;
         CRC_IN  = 1'b0;
         tick();
      end
      ACTIVE  = 1'b0;
      DATA    = 1'b0;
      CRC_VLD = 1'b0;
   endtask

   task automatic send_crc(input logic [7:0] c, input int n);
      for (int i = 0; i < n; i++) begin
         CRC_VLD = 1'b1;
         CRC_IN  = c[i];
         tick();
      end
      CRC_VLD = 1'b0;
      CRC_IN  = 1'b0;
   endtask

   initial begin
      int done_seen;
      int fail_frames;

      RST = 1'b1; DATA = 1'b0; ACTIVE = 1'b0; CRC_IN = 1'b0; CRC_VLD = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      chk("rst_done", 8'(DONE), 8'h0);
      chk("rst_ok", 8'(CRC_OK), 8'h0);
      chk("rst_len", 8'(LEN_ERR), 8'h0);
      chk("rst_errcnt", ERR_CNT, 8'h00);

      // Good frame: data 00 leaves LFSR at 14.
      send_data(8'h00, 1'b0);
      chk("a_done_early", 8'(DONE), 8'h0);
      send_crc(8'h14, 7);
      chk("a_done_7bits", 8'(DONE), 8'h0);
      send_crc(8'h14 >> 7, 1);
      chk("a_done", 8'(DONE), 8'h1);
      chk("a_ok", 8'(CRC_OK), 8'h1);
      chk("a_len", 8'(LEN_ERR), 8'h0);
      tick();
      chk("a_done_pulse", 8'(DONE), 8'h0);
      chk("a_ok_idle", 8'(CRC_OK), 8'h0);

      // Bit 2 of the CRC flipped.
      send_data(8'h00, 1'b0);
      send_crc(8'h10, 8);
      chk("b_done", 8'(DONE), 8'h1);
      chk("b_ok", 8'(CRC_OK), 8'h0);
      chk("b_len", 8'(LEN_ERR), 8'h0);
      tick();
      chk("b_errcnt", ERR_CNT, ec_exp(1));

      // CRC_VLD dropped after 5 bits.
      send_data(8'h00, 1'b0);
      send_crc(8'h14, 5);
      tick();
      chk("c_done", 8'(DONE), 8'h1);
      chk("c_ok", 8'(CRC_OK), 8'h0);
      chk("c_len", 8'(LEN_ERR), 8'h1);
      tick();
      chk("c_errcnt", ERR_CNT, ec_exp(2));

      // ACTIVE reasserted in the middle of the CRC phase.
      send_data(8'h00, 1'b0);
      send_crc(8'h14, 3);
      ACTIVE = 1'b1; CRC_VLD = 1'b1; CRC_IN = 1'b0;
      tick();
      ACTIVE = 1'b0; CRC_VLD = 1'b0;
      chk("d_done", 8'(DONE), 8'h1);
      chk("d_ok", 8'(CRC_OK), 8'h0);
      chk("d_len", 8'(LEN_ERR), 8'h1);
      tick();
      chk("d_errcnt", ERR_CNT, ec_exp(3));

      // Back-to-back frames, second ACTIVE rising in the REPORT cycle.
      send_data(8'h00, 1'b0);
      send_crc(8'h14, 8);
      chk("e1_done", 8'(DONE), 8'h1);
      chk("e1_ok", 8'(CRC_OK), 8'h1);
      send_data(8'h00, 1'b0);
      send_crc(8'h14, 8);
      chk("e2_done", 8'(DONE), 8'h1);
      chk("e2_ok", 8'(CRC_OK), 8'h1);
      tick();
      chk("e_errcnt", ERR_CNT, ec_exp(3));

      // CRC_VLD held high during data: ACTIVE wins, frame still good.
      send_data(8'h00, 1'b1);
      send_crc(8'h14, 8);
      chk("f_done", 8'(DONE), 8'h1);
      chk("f_ok", 8'(CRC_OK), 8'h1);
      tick();

      // Reset at CRC bit 4 abandons the frame.
      send_data(8'h00, 1'b0);
      send_crc(8'h14, 4);
      RST = 1'b1; CRC_VLD = 1'b1; CRC_IN = 1'b1;
      tick();
      RST = 1'b0; CRC_VLD = 1'b0; CRC_IN = 1'b0;
      chk("g_rst_done", 8'(DONE), 8'h0);
      chk("g_rst_ok", 8'(CRC_OK), 8'h0);
      chk("g_rst_len", 8'(LEN_ERR), 8'h0);
      chk("g_rst_errcnt", ERR_CNT, 8'h00);
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (DONE) done_seen++;
      end
      chk("g_no_done", 8'(done_seen), 8'h0);
      send_data(8'h00, 1'b0);
      send_crc(8'h14, 8);
      chk("g_clean_done", 8'(DONE), 8'h1);
      chk("g_clean_ok", 8'(CRC_OK), 8'h1);
      tick();

      // 300 corrupted frames back to back.
      fail_frames = 0;
      for (int i = 0; i < 300; i++) begin
         send_data(8'h00, 1'b0);
         send_crc(8'h10, 8);
         if (DONE && !CRC_OK) fail_frames++;
      end
      tick();
      chk("h_fail_frames", 8'(fail_frames - 44), 8'(256));
      chk("h_errcnt_sat", ERR_CNT, EC ? 8'hFF : 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crc_checker.md
# crc_checker

Serial CRC-8 receiver/checker, the far end of the team's serial CRC generator link. Takes a bit-serial data frame, then the 8-bit serial CRC the generator appends. Recomputes the CRC with the same LFSR, compares it bit by bit against the received CRC, and issues a one-cycle verdict. Sits on the receive side of the serial link, ahead of frame-acceptance logic.

## Interface
- `SEED`, 8'hD8: LFSR value loaded at frame start; must match the generator.
- `TAPS`, 8'b0100_0100: feedback XOR mask; bit i set means feedback is XORed into LFSR bit i.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: synchronous, active-high reset.
- `DATA` input 1: serial frame data, LSB first, sampled while `ACTIVE`=1.
- `ACTIVE` input 1: data phase qualifier, one bit per cycle.
- `CRC_IN` input 1: serial received CRC, LSB first, sampled while `CRC_VLD`=1.
- `CRC_VLD` input 1: CRC phase qualifier; high for exactly 8 consecutive cycles per frame.
- `DONE` output 1: one-cycle verdict strobe.
- `CRC_OK` output 1: valid when `DONE`=1; 1 means all 8 CRC bits matched.
- `LEN_ERR` output 1: valid when `DONE`=1; 1 means the CRC phase was malformed (fewer than 8 bits, or `ACTIVE` reasserted mid-CRC).
- `ERR_CNT` output 8: saturating count of failed frames (see Configuration).

## Operation
- FSM states: IDLE, DATA, CRC, REPORT.
- IDLE:
  - `ACTIVE`=1: load LFSR=`SEED`, apply the first data bit in the same cycle, go to DATA.
  - `CRC_VLD`=1 (no data phase): ignored, stay in IDLE.
- DATA, per cycle with `ACTIVE`=1: `fb = DATA ^ L[0]`; `L[7] <= fb`; `L[i] <= L[i+1] ^ (TAPS[i] & fb)` for i=0..6.
- DATA, on the first cycle with `ACTIVE`=0:
  - `CRC_VLD`=1: go to CRC and process that bit.
  - `CRC_VLD`=0: wait in DATA, LFSR frozen.
  - No limit on data length.
- CRC, per cycle with `CRC_VLD`=1:
  - `mismatch |= CRC_IN ^ L[0]`; `L <= {1'b0, L[7:1]}`; 3-bit bit counter increments.
  - On the 8th bit, go to REPORT.
- CRC, early termination: `CRC_VLD`=0 before 8 bits, or `ACTIVE`=1 at any point → set `len_err`, go to REPORT.
- REPORT (one cycle):
  - `DONE`=1, `CRC_OK` = !mismatch && !len_err, `LEN_ERR`=len_err.
  - Clear mismatch, len_err and the counter, then return to IDLE.
  - `ACTIVE`=1 during REPORT starts a new frame: reload `SEED`, take the bit, go to DATA.
- `CRC_OK` and `LEN_ERR` read 0 whenever `DONE`=0.

## Timing
- Reset (`RST`=1 at a rising edge):
  - Outputs: `DONE`=0, `CRC_OK`=0, `LEN_ERR`=0, `ERR_CNT`=0.
  - Internal: FSM=IDLE, LFSR=`SEED`, counter=0, flags=0.
- Reset mid-frame abandons the frame; no `DONE` is produced.
- Latency: `DONE` is asserted in the cycle after the edge that samples the 8th CRC bit.
- Back-to-back frames:
  - `ACTIVE` may rise in the REPORT cycle.
  - Minimum gap between the last CRC bit and the next first data bit is 1 cycle.
- `ACTIVE` and `CRC_VLD` both high in DATA: `ACTIVE` wins, the bit is treated as data.
- Bit counter wraps 7→0 only on the transition into REPORT.

## Configuration
- `CRC_CHK_ERRCNT_EN` defined:
  - `ERR_CNT` increments on every `DONE` with `CRC_OK`=0.
  - Saturates at 8'hFF.
  - Cleared only by `RST`.
- Not defined: `ERR_CNT` is tied to 8'h00 and has no counter logic. The port exists in both builds.

## Structure
- Shared package `crc_pkg` holds:
  - `CRC_W`=8, `CRC_SEED`=8'hD8, `CRC_TAPS`=8'b0100_0100.
  - The FSM state enum (IDLE/DATA/CRC/REPORT).
  - The generator reuses the same constants.
- One natural sub-module, `crc_lfsr`: the 8-bit LFSR with `load`, `shift_data` (feedback mode) and `shift_out` (plain right shift) controls. It is shared with the generator.

## Test plan
- Data 8'h00 LSB first with seed D8: LFSR=8'h14 at data end. Send CRC bits 0,0,1,0,1,0,0,0 → `DONE` with `CRC_OK`=1, `LEN_ERR`=0, one cycle after the 8th bit.
- Same frame, CRC bit 2 flipped (received 8'h10) → `CRC_OK`=0, `LEN_ERR`=0; `ERR_CNT`=1 with the macro, 0 without.
- Data 8'h00, `CRC_VLD` dropped after 5 bits → `DONE`, `CRC_OK`=0, `LEN_ERR`=1.
- Two back-to-back 8'h00 frames with correct CRC, second `ACTIVE` rising in the REPORT cycle → two `DONE` pulses, both `CRC_OK`=1.
- `RST` pulsed at CRC bit 4 → no `DONE`, all outputs 0. A following clean frame passes with `CRC_OK`=1.
- With the macro, 300 corrupted frames → `ERR_CNT` holds 8'hFF.
